// File: rtl/mod_pkg.sv
// mod_pkg: shared types and default parameter values for fm_am_modulator.
package mod_pkg;

   // Output mode, encoded exactly as presented on the mode input.
   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_FM   = 2'b01,
      MODE_AM   = 2'b10,
      MODE_MUTE = 2'b11
   } mode_e;

   // Configuration-sequencing states.
   typedef enum logic [1:0] {
      ST_WARMUP  = 2'b00,
      ST_RUN     = 2'b01,
      ST_PENDING = 2'b10
   } state_e;

   localparam int DEF_OUT_W     = 8;
   localparam int DEF_PHASE_W   = 32;
   localparam int DEF_LUT_AW    = 8;
   localparam int DEF_DEV_SHIFT = 8;

endpackage

// File: rtl/nco_core.sv
// nco_core: phase accumulator (stage 1) feeding a registered sine lookup
// (stage 2). wrap_o marks the enabled cycle whose add carries out of the
// accumulator's top bit.
module nco_core #(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 8,
   parameter int OUT_W   = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en_i,
   input  logic [PHASE_W-1:0]      tune_i,
   output logic                    wrap_o,
   output logic signed [OUT_W-1:0] sine_o
);

   localparam int HALF   = 2 ** (LUT_AW - 1);
   localparam int PEAK   = 2 ** (OUT_W - 1) - 1;
   localparam int SHIFT  = 2 * LUT_AW - 4;
   localparam int PROD_W = 2 * LUT_AW + OUT_W;

   // Sine table addressed by the top LUT_AW phase bits. Each half period is
   // the parabola 4*x*(HALF-x)*PEAK/HALF^2, so a quarter-period address gives
   // exactly +/-PEAK and the table needs no stored contents.
   function automatic logic signed [OUT_W-1:0] sine_lut(input logic [LUT_AW-1:0] addr);
      logic [PROD_W-1:0] x;
      logic [PROD_W-1:0] xc;
      logic [PROD_W-1:0] prod;
      logic [OUT_W-1:0]  mag;
      x    = PROD_W'(addr[LUT_AW-2:0]);
      xc   = PROD_W'(HALF) - x;
      prod = (x * xc * PROD_W'(PEAK)) >> SHIFT;
      mag  = OUT_W'(prod);
      return addr[LUT_AW-1] ? -mag : mag;
   endfunction

   logic [PHASE_W-1:0]      phase_q, phase_d;
   logic                    carry;
   logic signed [OUT_W-1:0] sine_q;

   // Next phase and its carry out; the sum wraps modulo 2^PHASE_W.
   always_comb begin
      {carry, phase_d} = {1'b0, phase_q} + {1'b0, tune_i};
   end

   // Stage 1 accumulate and stage 2 lookup, both frozen while en_i is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= '0;
         sine_q  <= '0;
      end else if (en_i) begin
         // NOTE: non-blocking, so the lookup sees the phase from before this edge.
         phase_q <= phase_d;
         sine_q  <= sine_lut(phase_q[PHASE_W-1 -: LUT_AW]);
      end
   end

   assign wrap_o = en_i & carry;
   assign sine_o = sine_q;

endmodule

// File: rtl/fm_am_modulator.sv
// fm_am_modulator: message and carrier NCOs with passthrough / FM / AM /
// mute output selection and phase-continuous reconfiguration that takes
// effect on a message-oscillator wrap.
// Optional feature: define FM_AM_MODULATOR_AM_EN to build the AM multiplier;
// without it mode 10 outputs silence like mode 11.
module fm_am_modulator
   import mod_pkg::*;
#(
   parameter int OUT_W     = DEF_OUT_W,
   parameter int PHASE_W   = DEF_PHASE_W,
   parameter int LUT_AW    = DEF_LUT_AW,
   parameter int DEV_SHIFT = DEF_DEV_SHIFT
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic [1:0]              mode,
   input  logic [PHASE_W-1:0]      msg_ctrl,
   input  logic [PHASE_W-1:0]      carrier_base,
   input  logic                    cfg_load,
   output logic                    cfg_pending,
   output logic signed [OUT_W-1:0] sample_out,
   output logic                    sample_valid
);

   state_e                  state_q, state_d;
   logic                    warm_cnt_q, warm_cnt_d;
   logic                    warm_cap_q, warm_cap_d;
   logic                    apply;
   mode_e                   mode_q, mode_d, sh_mode_q, sh_mode_d;
   logic [PHASE_W-1:0]      msg_tune_q, msg_tune_d, sh_msg_q, sh_msg_d;
   logic [PHASE_W-1:0]      car_base_q, car_base_d, sh_car_q, sh_car_d;
   logic [PHASE_W-1:0]      msg_ext, fm_dev, car_tune;
   logic signed [OUT_W-1:0] msg_sine, car_sine;
   logic signed [OUT_W-1:0] sample_q, sample_d;
   logic                    msg_wrap;
   logic                    car_wrap_unused;

   // FSM state register plus the warm-up bookkeeping that travels with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_WARMUP;
         warm_cnt_q <= 1'b0;
         warm_cap_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         warm_cap_q <= warm_cap_d;
      end
   end

   // FSM next state: leave warm-up after two enabled cycles, apply a pending
   // configuration on the message wrap.
   always_comb begin
      // NOTE: every output defaulted first so no path leaves one unassigned (no latch).
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      warm_cap_d = warm_cap_q;
      apply      = 1'b0;
      unique case (state_q)
         ST_WARMUP: begin
            if (cfg_load) warm_cap_d = 1'b1;
            if (en) begin
               if (warm_cnt_q) begin
                  state_d    = ST_RUN;
                  apply      = 1'b1;
                  warm_cap_d = 1'b0;
               end else begin
                  warm_cnt_d = 1'b1;
               end
            end
         end
         ST_RUN:     if (cfg_load) state_d = ST_PENDING;
         ST_PENDING: if (msg_wrap) begin
            state_d = ST_RUN;
            apply   = 1'b1;
         end
         default:    state_d = ST_WARMUP;
      endcase
   end

   // FSM outputs: pending flag and the valid qualifier gated by en.
   always_comb begin
      cfg_pending  = (state_q == ST_PENDING) || warm_cap_q;
      sample_valid = en && (state_q != ST_WARMUP);
   end

   // Shadow capture on cfg_load; the latest capture (even in the apply cycle) wins.
   always_comb begin
      sh_mode_d  = cfg_load ? mode_e'(mode) : sh_mode_q;
      sh_msg_d   = cfg_load ? msg_ctrl      : sh_msg_q;
      sh_car_d   = cfg_load ? carrier_base  : sh_car_q;
      mode_d     = apply ? sh_mode_d : mode_q;
      msg_tune_d = apply ? sh_msg_d  : msg_tune_q;
      car_base_d = apply ? sh_car_d  : car_base_q;
   end

   // Shadow and active configuration registers; accumulators are never touched here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_mode_q  <= MODE_MUTE;
         sh_msg_q   <= '0;
         sh_car_q   <= '0;
         mode_q     <= MODE_MUTE;
         msg_tune_q <= '0;
         car_base_q <= '0;
      end else begin
         sh_mode_q  <= sh_mode_d;
         sh_msg_q   <= sh_msg_d;
         sh_car_q   <= sh_car_d;
         mode_q     <= mode_d;
         msg_tune_q <= msg_tune_d;
         car_base_q <= car_base_d;
      end
   end

   // Carrier tuning: centre frequency, plus the sign-extended scaled message in FM.
   always_comb begin
      msg_ext  = {{(PHASE_W-OUT_W){msg_sine[OUT_W-1]}}, msg_sine};
      fm_dev   = msg_ext << DEV_SHIFT;
      car_tune = car_base_q;
      if (mode_q == MODE_FM) car_tune = car_base_q + fm_dev;
   end

   nco_core #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_msg (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en),
      .tune_i  (msg_tune_q),
      .wrap_o  (msg_wrap),
      .sine_o  (msg_sine)
   );

   nco_core #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_car (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en),
      .tune_i  (car_tune),
      .wrap_o  (car_wrap_unused),
      .sine_o  (car_sine)
   );

`ifdef FM_AM_MODULATOR_AM_EN
   logic signed [OUT_W:0]   msg_off;
   logic signed [2*OUT_W:0] am_prod;
   logic [OUT_W-1:0]        am_sample;
   logic                    am_unused;

   // AM: carrier times (message + 2^(OUT_W-1)), arithmetic shift right by OUT_W.
   always_comb begin
      msg_off   = $signed({msg_sine[OUT_W-1], msg_sine})
                + $signed({2'b01, {(OUT_W-1){1'b0}}});
      am_prod   = (2*OUT_W+1)'(car_sine) * (2*OUT_W+1)'(msg_off);
      am_sample = am_prod[2*OUT_W-1:OUT_W];
   end

   assign am_unused = ^{am_prod[2*OUT_W], am_prod[OUT_W-1:0]};
`endif

   // Stage 3 output selection.
   always_comb begin
      sample_d = '0;
      unique case (mode_q)
         MODE_PASS: sample_d = msg_sine;
         MODE_FM:   sample_d = car_sine;
`ifdef FM_AM_MODULATOR_AM_EN
         MODE_AM:   sample_d = am_sample;
`endif
         default:   sample_d = '0;
      endcase
   end

   // Stage 3 register, frozen with the rest of the pipeline while en is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  sample_q <= '0;
      else if (en)   sample_q <= sample_d;
   end

   assign sample_out = sample_q;

endmodule

// File: tb/tb_fm_am_modulator.sv
// Directed bench for fm_am_modulator with default parameters. Sine values of
// the parabolic table: addr 0x00/0x80 -> 0, 0x20/0x60 -> 95, 0x40 -> 127,
// 0xA0/0xE0 -> -95, 0xC0 -> -127.
module tb_fm_am_modulator;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              en;
   logic [1:0]        mode;
   logic [31:0]       msg_ctrl;
   logic [31:0]       carrier_base;
   logic              cfg_load;
   logic              cfg_pending;
   logic signed [7:0] sample_out;
   logic              sample_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   fm_am_modulator dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .en           (en),
      .mode         (mode),
      .msg_ctrl     (msg_ctrl),
      .carrier_base (carrier_base),
      .cfg_load     (cfg_load),
      .cfg_pending  (cfg_pending),
      .sample_out   (sample_out),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One rising edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      en = 1'b1; cfg_load = 1'b0; mode = 2'b11; msg_ctrl = '0; carrier_base = '0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Strobe cfg_load across exactly one rising edge.
   task automatic drive_cfg(input logic [1:0] m, input logic [31:0] mc, input logic [31:0] cb);
      cfg_load = 1'b1; mode = m; msg_ctrl = mc; carrier_base = cb;
      step();
      cfg_load = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      en = 1'b1; cfg_load = 1'b0; mode = 2'b11; msg_ctrl = '0; carrier_base = '0;
      step();
      tests_run++;
      if ({sample_out, sample_valid, cfg_pending} !== 10'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got sample=%0d valid=%b pending=%b expected 0/0/0",
                  sample_out, sample_valid, cfg_pending);
      end
      tests_run++;
      if (dut.u_msg.phase_q !== 32'h0 || dut.u_car.phase_q !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_phase: got msg=%h car=%h expected 0", dut.u_msg.phase_q, dut.u_car.phase_q);
      end
   endtask

   task automatic test_passthrough();
      int exp_s [10] = '{0, 0, 95, 127, 95, 0, -95, -127, -95, 0};
      logic signed [7:0] e;
      apply_reset();
      drive_cfg(2'b00, 32'h2000_0000, 32'h1000_0000);  // E1 (warm-up capture)
      tests_run++;
      if (sample_valid !== 1'b0 || cfg_pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL pass_warmup: got valid=%b pending=%b expected 0/1", sample_valid, cfg_pending);
      end
      step();                                          // E2 -> RUN
      tests_run++;
      if (sample_valid !== 1'b1 || cfg_pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL pass_run_entry: got valid=%b pending=%b expected 1/0", sample_valid, cfg_pending);
      end
      for (int i = 0; i < 10; i++) begin               // E3..E12
         step();
         e = 8'(exp_s[i]);
         tests_run++;
         if (sample_out !== e) begin
            tests_failed++;
            $display("FAIL pass_sample[%0d]: got %0d expected %0d", i, sample_out, e);
         end
      end
   endtask

   task automatic test_cfg_switch();
      int exp_s [4] = '{0, 127, 0, -127};
      logic signed [7:0] e;
      apply_reset();
      drive_cfg(2'b00, 32'h2000_0000, 32'h1000_0000);  // E1
      step(); step(); step();                          // E2..E4
      drive_cfg(2'b00, 32'h4000_0000, 32'h0800_0000);  // E5 -> PENDING
      for (int i = 5; i <= 9; i++) begin
         tests_run++;
         if (cfg_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL switch_pending_E%0d: got %b expected 1", i, cfg_pending);
         end
         step();
      end
      // Now just past E10: message wrap applied the new configuration.
      tests_run++;
      if (cfg_pending !== 1'b0 || dut.u_car.phase_q !== 32'h8000_0000 || sample_out !== -8'sd127) begin
         tests_failed++;
         $display("FAIL switch_wrap: got pending=%b car=%h sample=%0d expected 0/80000000/-127",
                  cfg_pending, dut.u_car.phase_q, sample_out);
      end
      step();                                          // E11
      tests_run++;
      if (dut.u_car.phase_q !== 32'h8800_0000 || sample_out !== -8'sd95) begin
         tests_failed++;
         $display("FAIL switch_continuous: got car=%h sample=%0d expected 88000000/-95",
                  dut.u_car.phase_q, sample_out);
      end
      step();                                          // E12
      tests_run++;
      if (dut.u_car.phase_q !== 32'h9000_0000) begin
         tests_failed++;
         $display("FAIL switch_car_step: got %h expected 90000000", dut.u_car.phase_q);
      end
      for (int i = 0; i < 4; i++) begin                // E12..E15 samples
         if (i > 0) step();
         e = 8'(exp_s[i]);
         tests_run++;
         if (sample_out !== e) begin
            tests_failed++;
            $display("FAIL switch_sample[%0d]: got %0d expected %0d", i, sample_out, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int exp_s [3] = '{0, 127, 0};
      logic signed [7:0] e;
      apply_reset();
      drive_cfg(2'b00, 32'h2000_0000, 32'h1000_0000);  // E1
      step(); step(); step();                          // E2..E4
      drive_cfg(2'b11, 32'h4000_0000, 32'h0000_0000);  // E5 first load (mute)
      step();                                          // E6
      drive_cfg(2'b00, 32'h4000_0000, 32'h0800_0000);  // E7 second load wins
      tests_run++;
      if (cfg_pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_pending: got %b expected 1", cfg_pending);
      end
      step(); step(); step();                          // E8..E10 (wrap at E10)
      tests_run++;
      if (cfg_pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_applied: got pending=%b expected 0", cfg_pending);
      end
      step();                                          // E11
      tests_run++;
      if (dut.u_car.phase_q !== 32'h8800_0000) begin
         tests_failed++;
         $display("FAIL b2b_car_tune: got %h expected 88000000", dut.u_car.phase_q);
      end
      for (int i = 0; i < 3; i++) begin                // E12..E14
         step();
         e = 8'(exp_s[i]);
         tests_run++;
         if (sample_out !== e) begin
            tests_failed++;
            $display("FAIL b2b_sample[%0d]: got %0d expected %0d", i, sample_out, e);
         end
      end
   endtask

   task automatic test_fm();
      int exp_s [4] = '{0, 0, 95, 127};
      logic signed [7:0] e;
      apply_reset();
      drive_cfg(2'b01, 32'h0000_0000, 32'h2000_0000);  // E1
      step();                                          // E2
      for (int i = 0; i < 4; i++) begin                // E3..E6
         step();
         e = 8'(exp_s[i]);
         tests_run++;
         if (sample_out !== e) begin
            tests_failed++;
            $display("FAIL fm_sample[%0d]: got %0d expected %0d", i, sample_out, e);
         end
      end
      apply_reset();
      drive_cfg(2'b01, 32'h0000_0000, 32'h0001_F751);  // E1
      step();                                          // E2
      tests_run++;
      if (dut.car_tune !== 32'h0001_F751) begin
         tests_failed++;
         $display("FAIL fm_tune_zero: got %h expected 0001f751", dut.car_tune);
      end
      force dut.msg_sine = 8'sh80;
      #1;
      tests_run++;
      if (dut.car_tune !== 32'h0001_7751) begin
         tests_failed++;
         $display("FAIL fm_tune_neg_full: got %h expected 00017751", dut.car_tune);
      end
      force dut.msg_sine = 8'sh7F;
      #1;
      tests_run++;
      if (dut.car_tune !== 32'h0002_7651) begin
         tests_failed++;
         $display("FAIL fm_tune_pos_full: got %h expected 00027651", dut.car_tune);
      end
      release dut.msg_sine;
      #1;
   endtask

   task automatic test_am();
`ifdef FM_AM_MODULATOR_AM_EN
      int exp_s [7] = '{0, 0, 126, 0, -1, 0, 126};
`else
      int exp_s [7] = '{0, 0, 0, 0, 0, 0, 0};
`endif
      logic signed [7:0] e;
      apply_reset();
      drive_cfg(2'b10, 32'h4000_0000, 32'h4000_0000);  // E1
      step();                                          // E2
      for (int i = 0; i < 7; i++) begin                // E3..E9
         step();
         e = 8'(exp_s[i]);
         tests_run++;
         if (sample_out !== e || sample_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL am_sample[%0d]: got %0d valid=%b expected %0d valid=1",
                     i, sample_out, sample_valid, e);
         end
      end
   endtask

   task automatic test_mute();
      apply_reset();
      drive_cfg(2'b11, 32'h4000_0000, 32'h4000_0000);  // E1
      step();                                          // E2
      for (int i = 0; i < 4; i++) begin                // E3..E6
         step();
         tests_run++;
         if (sample_out !== 8'sd0 || sample_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mute[%0d]: got sample=%0d valid=%b expected 0/1", i, sample_out, sample_valid);
         end
      end
   endtask

   task automatic test_en_hold();
      apply_reset();
      drive_cfg(2'b00, 32'h2000_0000, 32'h1000_0000);  // E1
      repeat (5) step();                               // E2..E6
      tests_run++;
      if (sample_out !== 8'sd127) begin
         tests_failed++;
         $display("FAIL hold_before: got %0d expected 127", sample_out);
      end
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         tests_run++;
         if (sample_out !== 8'sd127 || sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_cycle[%0d]: got sample=%0d valid=%b expected 127/0",
                     i, sample_out, sample_valid);
         end
      end
      en = 1'b1;
      step();                                          // E7
      tests_run++;
      if (sample_out !== 8'sd95 || sample_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_resume: got sample=%0d valid=%b expected 95/1", sample_out, sample_valid);
      end
   endtask

   task automatic test_reset_pending();
      apply_reset();
      drive_cfg(2'b00, 32'h2000_0000, 32'h1000_0000);  // E1
      step(); step(); step();                          // E2..E4
      drive_cfg(2'b00, 32'h4000_0000, 32'h0000_0000);  // E5 -> PENDING
      step();                                          // E6, sample 127
      tests_run++;
      if (cfg_pending !== 1'b1 || sample_out !== 8'sd127) begin
         tests_failed++;
         $display("FAIL rstpend_setup: got pending=%b sample=%0d expected 1/127", cfg_pending, sample_out);
      end
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if (cfg_pending !== 1'b0 || sample_out !== 8'sd0 || sample_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstpend_async: got pending=%b sample=%0d valid=%b expected 0/0/0",
                  cfg_pending, sample_out, sample_valid);
      end
      #2 reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         tests_run++;
         if (cfg_pending !== 1'b0 || sample_out !== 8'sd0) begin
            tests_failed++;
            $display("FAIL rstpend_discard[%0d]: got pending=%b sample=%0d expected 0/0",
                     i, cfg_pending, sample_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_cfg_switch();
      test_back_to_back();
      test_fm();
      test_am();
      test_mute();
      test_en_hold();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fm_am_modulator.md
FM_AM_MODULATOR -- requirements
Module: fm_am_modulator

Interface
REQ-001 Parameter OUT_W, default 8: sample width, signed two's complement.
REQ-002 Parameter PHASE_W, default 32: phase accumulator and tuning-word width.
REQ-003 Parameter LUT_AW, default 8: sine table address bits, taken from phase MSBs.
REQ-004 Parameter DEV_SHIFT, default 8: left shift applied to message for FM deviation.
REQ-005 clk  in  1  system clock, 100 MHz; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 en  in  1  advance enable; low freezes both accumulators and pipeline.
REQ-008 mode  in  2  00 message passthrough, 01 FM, 10 AM, 11 mute.
REQ-009 msg_ctrl  in  PHASE_W  message oscillator tuning word.
REQ-010 carrier_base  in  PHASE_W  carrier centre-frequency tuning word.
REQ-011 cfg_load  in  1  one-cycle strobe capturing mode/msg_ctrl/carrier_base into shadow registers.
REQ-012 cfg_pending  out  1  high while a captured configuration awaits application.
REQ-013 sample_out  out  OUT_W  modulated sample, signed.
REQ-014 sample_valid  out  1  high in every cycle sample_out reflects a pipeline result.

Function
REQ-015 Two internal oscillators SHALL each hold a PHASE_W accumulator, adding their tuning word per enabled cycle, wrapping modulo 2^PHASE_W.
REQ-016 Message tuning word = active msg_ctrl; carrier tuning word in FM = carrier_base + (sign-extended message << DEV_SHIFT), modulo 2^PHASE_W; other modes use carrier_base alone.
REQ-017 Message SHALL be sign-extended, never magnitude-converted; message = -2^(OUT_W-1) SHALL yield deviation exactly -2^(OUT_W-1+DEV_SHIFT).
REQ-018 Pipeline: stage 1 accumulate, stage 2 sine lookup, stage 3 mode mux/AM multiply; latency from accumulator update to sample_out = 2 enabled cycles.
REQ-019 AM output = (carrier x (message + 2^(OUT_W-1))) arithmetic-shifted right by OUT_W, truncated to OUT_W bits.
REQ-020 Mode 11 SHALL drive sample_out to 0 with sample_valid still asserted.
REQ-021 State machine: WARMUP (after reset, 2 enabled cycles, sample_valid low) -> RUN; RUN + cfg_load -> PENDING; PENDING -> RUN on message accumulator wrap (carry out), shadow copied to active registers in that cycle.
REQ-022 cfg_load in PENDING SHALL overwrite the shadow registers; the last captured value wins.
REQ-023 cfg_load in WARMUP SHALL be captured and applied when RUN is entered.
REQ-024 Configuration changes SHALL never reset either phase accumulator (phase-continuous switching).
REQ-025 en low: state, accumulators, pipeline hold; sample_valid low; wrap detection only on enabled cycles.

Reset
REQ-026 reset_n low: accumulators, pipeline, sample_out = 0, sample_valid = 0, cfg_pending = 0, state = WARMUP, active/shadow mode = 11, tuning words = 0.
REQ-027 Reset asserted mid-PENDING SHALL discard the shadow configuration.

Configuration
REQ-028 Macro FM_AM_MODULATOR_AM_EN defined: AM path and multiplier compiled in, mode 10 per REQ-019.
REQ-029 Macro undefined: no multiplier instantiated; mode 10 behaves as mode 11.

Structure
REQ-030 Shared package mod_pkg SHALL hold the mode enumeration, state enumeration, and default parameter constants.
REQ-031 One sub-module nco_core (accumulator + sine LUT, parametrised by PHASE_W, LUT_AW, OUT_W), instantiated twice.

Verification
REQ-032 Reset release, en=1, mode=00 via cfg_load: sample_valid rises after 2 cycles; sample_out follows message sine.
REQ-033 FM, carrier_base=0x1F751, DEV_SHIFT=8, message forced to 0x80: carrier tuning word = 0x1F751 - 0x8000 = 0x17751.
REQ-034 cfg_load mid-period: cfg_pending high until message accumulator wrap, then low; carrier phase continuous across switch.
REQ-035 Two cfg_load strobes within PENDING: only second configuration applied at wrap.
REQ-036 With AM_EN, message = +127, carrier peak +127: sample_out = (127 x 255) >>> 8 = 126; without AM_EN mode 10 gives 0.
REQ-037 en held low 10 cycles: sample_out constant, sample_valid low; reset_n pulsed during PENDING: cfg_pending 0, sample_out 0.
